// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage registered delay line with per-stage valid, stall, flush and occupancy.
// Latency DEPTH enabled edges; en=0 freezes all state; optional `DFF_PIPE_TAP_EN exposes every stage on taps.
module dff_pipe #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  input  logic                       en,
  input  logic                       flush,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef DFF_PIPE_TAP_EN
  ,
  output logic [WIDTH*DEPTH-1:0]     taps
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;

  // Modular arithmetic is exact here: the true result always lies in 0..DEPTH.
  assign w_occ_nxt = r_occ + OCC_W'(d_valid) - OCC_W'(r_vld[DEPTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_vld <= '0;
      r_occ <= '0;
    end else if (flush) begin
      r_vld <= '0;
      r_occ <= '0;
    end else if (en) begin
      r_data[0] <= d;
      r_vld[0]  <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_occ <= w_occ_nxt;
    end
  end

  assign q         = r_data[DEPTH-1];
  assign q_valid   = r_vld[DEPTH-1];
  assign occupancy = r_occ;

`ifdef DFF_PIPE_TAP_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    assign taps[g*WIDTH +: WIDTH] = r_data[g];
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed test-plan scenarios plus random traffic, scored against a slot-queue model.
module tb_dff_pipe;

  localparam int         W   = 8;
  localparam int         D   = 4;
  localparam logic [7:0] RV  = 8'hA5;
  localparam logic [7:0] RV1 = 8'h3C;

  logic       clk = 1'b0;
  logic       reset = 1'b0, d_valid = 1'b0, en = 1'b0, flush = 1'b0;
  logic [7:0] d = '0;
  logic [7:0] q, q1;
  logic       q_valid, q_valid1;
  logic [2:0] occupancy;
  logic [0:0] occupancy1;
`ifdef DFF_PIPE_TAP_EN
  logic [31:0] taps;
  logic [7:0]  taps1;
`endif

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) u_dut (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .en(en), .flush(flush),
    .q(q), .q_valid(q_valid), .occupancy(occupancy)
`ifdef DFF_PIPE_TAP_EN
    , .taps(taps)
`endif
  );

  dff_pipe #(.WIDTH(W), .DEPTH(1), .RESET_VAL(RV1)) u_dut1 (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .en(en), .flush(flush),
    .q(q1), .q_valid(q_valid1), .occupancy(occupancy1)
`ifdef DFF_PIPE_TAP_EN
    , .taps(taps1)
`endif
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       vld;
  } slot_t;

  slot_t      pipe[$];   // pipe[0] = newest slot, pipe[D-1] = output slot
  slot_t      p1;        // single-stage reference
  logic [7:0] exp_q[$];  // valid words in flight, oldest first
  bit         mon_on  = 1'b0;
  bit         shifted = 1'b0;
  int         n_chk   = 0;
  int         n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int valid_count();
    int c = 0;
    foreach (pipe[i]) c += int'(pipe[i].vld);
    return c;
  endfunction

  // Reference behaviour for one rising edge, from the inputs currently applied.
  task automatic model_edge();
    shifted = 1'b0;
    if (reset) begin
      pipe.delete();
      repeat (D) pipe.push_back(slot_t'{dat: RV, vld: 1'b0});
      exp_q.delete();
      p1     = slot_t'{dat: RV1, vld: 1'b0};
      mon_on = 1'b1;
    end else if (flush) begin
      foreach (pipe[i]) begin
        slot_t s;
        s = pipe[i];
        s.vld = 1'b0;
        pipe[i] = s;
      end
      exp_q.delete();
      p1.vld = 1'b0;
    end else if (en) begin
      pipe.push_front(slot_t'{dat: d, vld: d_valid});
      void'(pipe.pop_back());
      if (d_valid) exp_q.push_back(d);
      p1      = slot_t'{dat: d, vld: d_valid};
      shifted = 1'b1;
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic e, input logic v, input logic [7:0] dd);
    @(negedge clk);
    reset = r; flush = f; en = e; d_valid = v; d = dd;
    @(posedge clk);
    model_edge();
  endtask

  // Monitor: every cycle compares outputs with the model; a new valid word on q pops the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("q_valid", 32'(q_valid), 32'(pipe[D-1].vld));
        check("q_data", 32'(q), 32'(pipe[D-1].dat));
        check("occupancy", 32'(occupancy), 32'(valid_count()));
        check("d1_q", 32'(q1), 32'(p1.dat));
        check("d1_q_valid", 32'(q_valid1), 32'(p1.vld));
        check("d1_occupancy", 32'(occupancy1), 32'(p1.vld));
`ifdef DFF_PIPE_TAP_EN
        for (int i = 0; i < D; i++) check("taps", 32'(taps[i*8 +: 8]), 32'(pipe[i].dat));
        check("d1_taps", 32'(taps1), 32'(p1.dat));
`endif
        if (shifted && q_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(q), 32'hxxxx_xxxx);
          end else begin
            check("sb_word", 32'(q), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    // Reset held over 2 edges with everything else active.
    drive(1, 0, 1, 1, 8'hFF);
    drive(1, 0, 1, 1, 8'hFF);
    #1;
    check("rst_q", 32'(q), 32'hA5);
    check("rst_q_valid", 32'(q_valid), 32'h0);
    check("rst_occupancy", 32'(occupancy), 32'h0);
`ifdef DFF_PIPE_TAP_EN
    check("rst_taps", taps, 32'hA5A5A5A5);
`endif

    // Streaming
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 1, 8'(k));
      if (k == 4) begin
        #1;
        check("stream_first", 32'(q), 32'h01);
        check("stream_occ", 32'(occupancy), 32'h4);
      end
    end
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 0, 8'h00);

    // Stall
    drive(0, 0, 1, 1, 8'h10);
    drive(0, 0, 1, 1, 8'h11);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 8'($urandom));
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    #1;
    check("stall_q", 32'(q), 32'h10);
    check("stall_q_valid", 32'(q_valid), 32'h1);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 8'h00);

    // Bubbles
    for (int k = 0; k < 8; k++) drive(0, 0, 1, 1'(~k[0]), 8'(8'h20 + (k % 4)));

    // Flush while enabled
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 1, 8'(8'h30 + k));
    drive(0, 1, 1, 1, 8'h77);
    #1;
    check("flush_occ", 32'(occupancy), 32'h0);
    check("flush_q_valid", 32'(q_valid), 32'h0);
    check("flush_q", 32'(q), 32'h30);
    for (int k = 0; k < 5; k++) drive(0, 0, 1, 0, 8'h00);

    // Mid-stream reset
    drive(0, 0, 1, 1, 8'h50);
    drive(0, 0, 1, 1, 8'h51);
    drive(1, 0, 1, 1, 8'h52);
    #1;
    check("mrst_q", 32'(q), 32'hA5);
    check("mrst_occ", 32'(occupancy), 32'h0);
    drive(0, 0, 1, 1, 8'h42);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 8'h00);
    #1;
    check("mrst_word", 32'(q), 32'h42);
    check("mrst_q_valid", 32'(q_valid), 32'h1);
    check("mrst_occ_after", 32'(occupancy), 32'h1);

    // Random traffic, including reset+flush collisions
    for (int k = 0; k < 2000; k++) begin
      drive(1'($urandom_range(99) == 0), 1'($urandom_range(19) == 0),
            1'($urandom_range(3) != 0), 1'($urandom_range(1)), 8'($urandom));
    end

    // Drain: every issued word must have been seen
    for (int k = 0; k < D; k++) drive(0, 0, 1, 0, 8'h00);
    @(negedge clk);
    #1;
    check("drain_left", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised successor to the single-bit `d_flipflop`. It is a WIDTH-bit, DEPTH-stage registered delay line with a per-stage valid bit, a global stall enable, a flush, and a registered occupancy count. It sits between producer and consumer logic wherever the design needs fixed-latency retiming of a data word and its qualifier, and it replaces chains of hand-instantiated flip-flops.

## Interface
Parameters:
- `WIDTH`, default 1: data bits per stage. Must be ≥ 1.
- `DEPTH`, default 4: number of stages, which is also the latency in enabled cycles. Must be ≥ 1.
- `RESET_VAL`, default 0: value loaded into every data stage on reset. WIDTH bits.

Ports:
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `d`, input, WIDTH: data in.
- `d_valid`, input, 1: qualifier for `d`.
- `en`, input, 1: advance enable. 1 shifts the pipe; 0 holds all state.
- `flush`, input, 1: clears all valid bits.
- `q`, output, WIDTH: data in the last stage (DEPTH-1).
- `q_valid`, output, 1: valid bit of the last stage.
- `occupancy`, output, `$clog2(DEPTH+1)`: number of stages currently holding valid = 1.
- `taps`, output, WIDTH*DEPTH: only present with `DFF_PIPE_TAP_EN` (see Configuration).

## Operation
- State:
  - data[0..DEPTH-1], each WIDTH bits.
  - vld[0..DEPTH-1], each 1 bit.
  - occ register.
- All state updates at the rising edge of `clk`, in this priority order:
  1. `reset`=1: every data[i] ← RESET_VAL, every vld[i] ← 0, occ ← 0. The values of `flush`, `en` and `d_valid` are ignored.
  2. `flush`=1: every vld[i] ← 0 and occ ← 0. data[] is unchanged. This holds even when `en`=1, and the incoming `d`/`d_valid` are discarded.
  3. `en`=1: the pipe shifts.
     - data[0] ← d and vld[0] ← d_valid.
     - data[i] ← data[i-1] and vld[i] ← vld[i-1], for i = 1..DEPTH-1.
     - occ ← occ + d_valid − vld[DEPTH-1]. This can never underflow or overflow.
  4. Otherwise: hold all state.
- Data always shifts when `en`=1, regardless of valid. An invalid slot carries whatever data was last in it.
- Outputs:
  - `q` = data[DEPTH-1].
  - `q_valid` = vld[DEPTH-1].
  - `occupancy` = occ.
  - All outputs are driven directly from registers, with no combinational path from any input.
- Invariant: `occupancy` equals the popcount of vld[] after every edge. The bench checks this every cycle.
- DEPTH=1: a single register stage. The occ width is 1, and the occ update rule still applies (for example, d_valid=1 with vld[0]=1 gives occ unchanged at 1).

## Timing
- Latency: a word sampled at an edge with `en`=1 appears on `q` after exactly DEPTH enabled edges.
  - With `en` held at 1, this means `d` at edge k appears on `q` from edge k+DEPTH-1 to edge k+DEPTH.
  - Cycles with `en`=0 extend the latency by one cycle each.
- Reset values, visible after the first edge with `reset`=1:
  - `q` = RESET_VAL.
  - `q_valid` = 0.
  - `occupancy` = 0.
  - `taps` = DEPTH copies of RESET_VAL.
- Reset during an active stream: in-flight words are lost. On the following edge with `en`=1 and `reset`=0, normal shifting resumes from the reset state.
- Flush takes effect at the same edge it is sampled. The next edge with `en`=1 and `d_valid`=1 gives occupancy = 1.
- Simultaneous `flush` and `en`: flush wins and no new word enters.
- Simultaneous `reset` and `flush`: reset wins, so data is also cleared to RESET_VAL.

## Configuration
- `DFF_PIPE_TAP_EN` defined:
  - Adds the output port `taps`, WIDTH*DEPTH bits, where `taps[i*WIDTH +: WIDTH]` = data[i].
  - Taps are registered outputs. They carry no valid qualification; the user combines them with `occupancy` externally.
- `DFF_PIPE_TAP_EN` not defined:
  - The `taps` port does not exist.
  - Behaviour of all other ports is identical.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, RESET_VAL=8'hA5.
- Reset: hold `reset`=1 for 2 edges with d=8'hFF, d_valid=1, en=1 → q=8'hA5, q_valid=0, occupancy=0, taps=32'hA5A5A5A5 (TAP_EN build).
- Streaming: en=1, feed valid words 8'h01, 8'h02, 8'h03, … on consecutive edges → q=8'h01 with q_valid=1 after the 4th edge, then one word per cycle in order. Occupancy reads 1, 2, 3, 4, 4, ….
- Stall: load 8'h10, 8'h11 and then drop `en` for 3 cycles → q, q_valid and occupancy are frozen during the stall. 8'h10 reaches `q` after 4 enabled edges, i.e. 3 cycles later than with `en` held at 1.
- Bubbles: pattern d_valid=1,0,1,0 with d=8'h20..8'h23 → q_valid toggles 1,0,1,0 from edge 4, and occupancy stays 2 from edge 4 onward.
- Flush with en=1: fill with 4 valid words, then assert `flush` with d=8'h77, d_valid=1 → next edge gives occupancy=0 and q_valid=0, q unchanged. 8'h77 never appears with q_valid=1.
- Mid-stream reset: after 2 valid words, assert `reset` for 1 edge → all outputs equal their reset values. A subsequent valid 8'h42 emerges after 4 edges with occupancy=1 at that point.
